// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DMEM_ADDR_W / DMEM_DATA_W / DMEM_MAX_WAIT : default geometry and debug starvation limit
//   owner_e : tag recording which port owns the read return due next cycle
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W   = 8;
  localparam int DMEM_DATA_W   = 16;
  localparam int DMEM_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU data port, the debug read port and the memory port.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants/returns/memory)
//   master : environment view (CPU, debug monitor and RAM together)
//
// Handshake semantics:
//   cpu_req is a request held by the CPU; it is accepted in any cycle where
//   cpu_req && !cpu_stall. dbg_req is held with a stable dbg_addr until the cycle
//   in which dbg_gnt is high; that cycle is the acceptance. A read accepted in
//   cycle N returns in cycle N+1 with a single-cycle cpu_rvalid/dbg_rvalid pulse.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU data port and the
// debug/display read port. The CPU has priority, but a debug request refused
// MAX_WAIT cycles in a row is forced through and the CPU is stalled for that cycle.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (CPU port, debug port, memory port)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input logic            clock,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_TOP = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt;
  owner_e            owner;
  logic [DATA_W-1:0] dbg_hold;

  logic force_dbg;
  logic cpu_win;
  logic dbg_win;

  // Grants are qualified with reset so that nothing is granted (and the CPU is
  // not stalled) while reset is held, even with requests pending.
  always_comb begin
    force_dbg = reset && bus.dbg_req && (wait_cnt == WAIT_TOP);
    cpu_win   = reset && bus.cpu_req && !force_dbg;
    dbg_win   = reset && bus.dbg_req && (!bus.cpu_req || force_dbg);
  end

  assign bus.mem_en    = cpu_win || dbg_win;
  assign bus.mem_we    = cpu_win && bus.cpu_we;
  assign bus.mem_addr  = cpu_win ? bus.cpu_addr : (dbg_win ? bus.dbg_addr : '0);
  assign bus.mem_wdata = cpu_win ? bus.cpu_wdata : '0;

  assign bus.cpu_stall = reset && bus.cpu_req && !cpu_win;
  assign bus.dbg_gnt   = dbg_win;

  // Returns are steered by the tag captured at grant time. The debug result is
  // shown straight from the RAM in the return cycle and held in dbg_hold after.
  assign bus.cpu_rvalid = (owner == OWN_CPU);
  assign bus.cpu_rdata  = (owner == OWN_CPU) ? bus.mem_rdata : '0;
  assign bus.dbg_rvalid = (owner == OWN_DBG);
  assign bus.dbg_rdata  = (owner == OWN_DBG) ? bus.mem_rdata : dbg_hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      owner    <= OWN_NONE;
      dbg_hold <= '0;
    end else begin
      if (owner == OWN_DBG) begin
        dbg_hold <= bus.mem_rdata;
      end

      // CPU writes produce no return, so they leave the tag at NONE.
      if (cpu_win && !bus.cpu_we) begin
        owner <= OWN_CPU;
      end else if (dbg_win) begin
        owner <= OWN_DBG;
      end else begin
        owner <= OWN_NONE;
      end

      if (!bus.dbg_req || dbg_win) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_TOP) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Synchronous single-port RAM: read data appears the cycle after a read enable.
  logic [DW-1:0] ram [256] = '{default: '0};
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: memory contents as the spec promises them, how many
  // consecutive cycles the debug port has been turned away, and the read
  // result owed to a port in the next cycle.
  logic [DW-1:0] shadow [256] = '{default: '0};
  int            refused;
  logic [DW-1:0] exp_q [$];      // data owed next cycle (0 or 1 entries)
  int            owed_to;        // 0 nobody, 1 cpu, 2 debug
  logic [DW-1:0] dbg_shown;
  bit            last_dbg_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    refused   = 0;
    owed_to   = 0;
    exp_q.delete();
    dbg_shown = '0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".cpu_stall"},  32'(bus.cpu_stall),  32'(0));
    check({tag, ".dbg_gnt"},    32'(bus.dbg_gnt),    32'(0));
    check({tag, ".mem_en"},     32'(bus.mem_en),     32'(0));
    check({tag, ".mem_we"},     32'(bus.mem_we),     32'(0));
    check({tag, ".mem_addr"},   32'(bus.mem_addr),   32'(0));
    check({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(0));
    check({tag, ".cpu_rdata"},  32'(bus.cpu_rdata),  32'(0));
    check({tag, ".dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(0));
    check({tag, ".dbg_rdata"},  32'(bus.dbg_rdata),  32'(0));
  endtask

  // ---------------- driver: one cycle, entered just after a falling edge ----------------
  task automatic step(input string tag, input bit creq, input bit cwe,
                      input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                      input bit dreq, input logic [AW-1:0] daddr);
    bit            forced, cpu_gets, dbg_gets;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] owed;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.dbg_req   = dreq;
    bus.dbg_addr  = daddr;
    #1;
    // Debug is pushed through once it has been turned away MAX_WAIT times.
    forced   = dreq && (refused >= MAX_WAIT);
    cpu_gets = creq && !forced;
    dbg_gets = dreq && !cpu_gets;
    e_addr   = cpu_gets ? caddr : (dbg_gets ? daddr : '0);
    owed     = (exp_q.size() != 0) ? exp_q[0] : '0;

    check({tag, ".cpu_stall"},  32'(bus.cpu_stall), 32'(creq && !cpu_gets));
    check({tag, ".dbg_gnt"},    32'(bus.dbg_gnt),   32'(dbg_gets));
    check({tag, ".mem_en"},     32'(bus.mem_en),    32'(cpu_gets || dbg_gets));
    check({tag, ".mem_we"},     32'(bus.mem_we),    32'(cpu_gets && cwe));
    check({tag, ".mem_addr"},   32'(bus.mem_addr),  32'(e_addr));
    check({tag, ".mem_wdata"},  32'(bus.mem_wdata), 32'(cpu_gets ? cwd : '0));
    check({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(owed_to == 1));
    check({tag, ".cpu_rdata"},  32'(bus.cpu_rdata),  32'((owed_to == 1) ? owed : '0));
    check({tag, ".dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(owed_to == 2));
    check({tag, ".dbg_rdata"},  32'(bus.dbg_rdata),  32'((owed_to == 2) ? owed : dbg_shown));

    // Advance the model across the coming rising edge.
    if (owed_to == 2) dbg_shown = owed;
    exp_q.delete();
    owed_to = 0;
    if (cpu_gets && !cwe) begin
      exp_q.push_back(shadow[caddr]);
      owed_to = 1;
    end else if (dbg_gets) begin
      exp_q.push_back(shadow[daddr]);
      owed_to = 2;
    end
    if (cpu_gets && cwe) shadow[caddr] = cwd;
    if (!dreq || dbg_gets) refused = 0;
    else if (refused < MAX_WAIT) refused++;
    last_dbg_gnt = dbg_gets;
    @(negedge clock);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit            dwait;
    logic [AW-1:0] dheld;
    bit            dr;
    logic [AW-1:0] da;
    model_reset();
    last_dbg_gnt = 1'b0;

    // T1: reset held with every request high
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h33; bus.cpu_wdata = 16'hAAAA;
    bus.dbg_req = 1'b1; bus.dbg_addr = 8'h44;
    repeat (3) @(negedge clock);
    #1;
    reset_checks("t1_reset");
    reset = 1'b1;
    step("t1_release", 1'b1, 1'b0, 8'h05, 16'h0, 1'b1, 8'h05);
    idle("t1_drain");

    // T2: CPU write then read back
    step("t2_wr", 1'b1, 1'b1, 8'h05, 16'h1234, 1'b0, '0);
    step("t2_rd", 1'b1, 1'b0, 8'h05, 16'h0, 1'b0, '0);
    idle("t2_ret");

    // T3: CPU busy every cycle, debug starves then is forced through
    for (int i = 0; i < 6; i++)
      step("t3_busy", 1'b1, 1'b0, 8'h10, 16'h0, !last_dbg_gnt || i == 0, 8'h05);
    idle("t3_ret");
    idle("t3_hold");

    // T4: back-to-back debug reads with CPU idle
    step("t4_wr", 1'b1, 1'b1, 8'h06, 16'hBEEF, 1'b0, '0);
    step("t4_d0", 1'b0, 1'b0, '0, '0, 1'b1, 8'h05);
    step("t4_d1", 1'b0, 1'b0, '0, '0, 1'b1, 8'h06);
    idle("t4_ret");
    idle("t4_hold");

    // T5: alternating CPU and debug reads
    for (int i = 0; i < 4; i++) begin
      step("t5_cpu", 1'b1, 1'b0, 8'h06, '0, 1'b0, '0);
      step("t5_dbg", 1'b0, 1'b0, '0, '0, 1'b1, 8'h05);
    end
    idle("t5_ret");

    // T6: reset the cycle after a CPU read grant; return must vanish
    step("t6_rd", 1'b1, 1'b0, 8'h05, '0, 1'b0, '0);
    reset = 1'b0;
    #1;
    check("t6_rst.cpu_rvalid", 32'(bus.cpu_rvalid), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    idle("t6_after");
    // Starvation count restarts from zero: debug forced on the fifth cycle again.
    last_dbg_gnt = 1'b0;
    for (int i = 0; i < 5; i++)
      step("t6_wait", 1'b1, 1'b1, 8'h20, 16'(i), 1'b1, 8'h06);
    idle("t6_ret");

    // Random traffic on a small address window to provoke collisions.
    dwait = 1'b0;
    dheld = '0;
    for (int i = 0; i < 400; i++) begin
      if (dwait) begin
        dr = ($urandom_range(0, 9) != 0);
        da = dheld;
      end else begin
        dr = ($urandom_range(0, 1) == 1);
        da = AW'($urandom_range(0, 15));
      end
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
           AW'($urandom_range(0, 15)), DW'($urandom), dr, da);
      dwait = dr && !last_dbg_gnt;
      dheld = da;
    end
    idle("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
